psum_ofifo: RTL and testbench
=============================

// Module: psum_ofifo
// PURPOSE
//   Output collection FIFO at the bottom of the MAC column array: the consumer
//   of each column's fifo_wr strobe and psum bus. Per-column circular buffers
//   absorb psums written at independent times (columns skew by pipeline delay).
//   A downstream reader pops one aligned row (one psum per column) per read
//   once every column holds data.
// PARAMETERS
//   col      8    number of MAC columns (independent write lanes)
//   bw_psum  22   psum width per column (2*bw+6, bw=8)
//   depth    16   entries per column buffer; power of 2, >=2
// PORTS
//   clk         in   1              clock, rising edge
//   reset       in   1              asynchronous, active-high reset
//   wr          in   col            per-column write strobe (column fifo_wr)
//   in          in   col*bw_psum    packed psums, column i at [i*bw_psum +: bw_psum]
//   rd          in   1              row pop request
//   out         out  col*bw_psum    registered popped row, same packing as in
//   o_rd_valid  out  1              1-cycle pulse: out holds a newly popped row
//   o_valid     out  1              all columns non-empty (row available)
//   o_full      out  1              any column full
//   o_overflow  out  1              sticky: a write hit a full column
// BEHAVIOUR
//   Reset (async assert, sync deassert by the driver): all rd/wr pointers 0,
//     out=0, o_rd_valid=0, o_overflow=0; o_valid=0, o_full=0. Contents are
//     discarded, including a reset asserted mid-stream.
//   Storage: per column, a depth x bw_psum array, rd_ptr/wr_ptr of
//     log2(depth)+1 bits (MSB = wrap bit). empty_i: ptrs equal. full_i: low
//     bits equal, MSBs differ. Pointers wrap modulo 2*depth without reset.
//   o_valid = AND(~empty_i); o_full = OR(full_i). Both combinational from
//     current pointers.
//   Write, column i: if wr[i] && !full_i, store in[i] at wr_ptr_i and
//     increment wr_ptr_i. If wr[i] && full_i, drop the data, leave the pointer
//     unchanged, and set o_overflow (sticky until reset).
//   Read: if rd && o_valid, register all head entries into out, advance every
//     rd_ptr_i by 1, and assert o_rd_valid on the next cycle for exactly 1 cycle.
//     rd while !o_valid is ignored: no pointer move, out holds, o_rd_valid=0.
//   Read latency: 1 clk from the accepted rd edge to out/o_rd_valid. out holds
//     its last value until the next accepted pop.
//   Simultaneous events (full/empty are evaluated on pre-edge state):
//     - wr to a full column with an accepted rd in the same cycle: write
//       dropped, overflow set; the read still pops.
//     - wr to an empty column with rd in the same cycle: the rd is ignored if
//       that empties o_valid; the write lands normally.
//     - wr and rd on a non-full, non-empty column: both occur; occupancy unchanged.
//   Widths: data is stored verbatim (signed psum bits are not altered).
// TESTING
//   1 reset, then wr=8'hFF with in[i]=i+1 for 1 cycle, rd=1 next cycle
//     -> o_valid=1 before rd; 1 clk after rd: out[i]=i+1, o_rd_valid pulse,
//     then o_valid=0.
//   2 skewed writes: column i written at cycle i (i=0..7), rd held high
//     -> no pop until cycle 7 write lands; exactly one row is popped, with
//     correct values.
//   3 fill column 0 with 16 writes (others empty), then write a 17th
//     -> o_full=1 after the 16th; o_overflow=1 after the 17th; o_valid=0; the
//     17th value is never read.
//   4 wrap: 40 rows of write+pop, values 0..39 (negative values in odd rows)
//     -> out sequence 0..39 in order, sign bits intact, o_overflow=0.
//   5 rd with all columns empty, then a write to all with rd in the same cycle
//     -> no o_rd_valid; row available next cycle and popped on the next rd.
//   6 reset asserted asynchronously mid-stream with 5 rows stored
//     -> outputs clear immediately without a clk edge; o_valid=0; old data
//     is never popped.

Source files
------------

// File: rtl/psum_ofifo.sv
// Output collection FIFO below the MAC column array: one circular buffer per
// column, written independently, popped as an aligned row once all columns hold data.
module psum_ofifo #(
    parameter int col     = 8,
    parameter int bw_psum = 22,
    parameter int depth   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [col-1:0]         wr,
    input  logic [col*bw_psum-1:0] in,
    input  logic                   rd,
    output logic [col*bw_psum-1:0] out,
    output logic                   o_rd_valid,
    output logic                   o_valid,
    output logic                   o_full,
    output logic                   o_overflow
);

    localparam int aw = $clog2(depth);
    localparam logic [aw:0] ptr_one = (aw+1)'(1);

    logic [bw_psum-1:0] mem [col][depth];
    logic [aw:0]        rd_ptr [col];
    logic [aw:0]        wr_ptr [col];
    logic [col-1:0]     empty_col;
    logic [col-1:0]     full_col;
    logic               rd_accept;

    // Pointer MSB is the wrap bit: equal pointers mean empty, differing MSBs full.
    always_comb begin
        empty_col = '0;
        full_col  = '0;
        for (int unsigned i = 0; i < col; i++) begin
            empty_col[i] = (rd_ptr[i] == wr_ptr[i]);
            full_col[i]  = (rd_ptr[i][aw-1:0] == wr_ptr[i][aw-1:0]) &&
                           (rd_ptr[i][aw] != wr_ptr[i][aw]);
        end
    end

    assign o_valid   = ~|empty_col;
    assign o_full    = |full_col;
    assign rd_accept = rd && o_valid;

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < col; i++) begin
            if (wr[i] && !full_col[i]) begin
                mem[i][wr_ptr[i][aw-1:0]] <= in[i*bw_psum +: bw_psum];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < col; i++) begin
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
            end
            out        <= '0;
            o_rd_valid <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            o_rd_valid <= rd_accept;
            for (int unsigned i = 0; i < col; i++) begin
                if (wr[i]) begin
                    if (full_col[i]) begin
                        o_overflow <= 1'b1;
                    end else begin
                        wr_ptr[i] <= wr_ptr[i] + ptr_one;
                    end
                end
                if (rd_accept) begin
                    out[i*bw_psum +: bw_psum] <= mem[i][rd_ptr[i][aw-1:0]];
                    rd_ptr[i] <= rd_ptr[i] + ptr_one;
                end
            end
        end
    end

endmodule

// File: tb/tb_psum_ofifo.sv
// Bench for psum_ofifo: directed scenarios plus random traffic, all checked
// against per-column queue model of the FIFO rules.
module tb_psum_ofifo;

    localparam int COL   = 8;
    localparam int BW    = 22;
    localparam int DEPTH = 16;

    logic                clk;
    logic                reset;
    logic [COL-1:0]      wr;
    logic [COL*BW-1:0]   in_bus;
    logic                rd;
    logic [COL*BW-1:0]   out_bus;
    logic                o_rd_valid;
    logic                o_valid;
    logic                o_full;
    logic                o_overflow;

    psum_ofifo #(
        .col     (COL),
        .bw_psum (BW),
        .depth   (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wr         (wr),
        .in         (in_bus),
        .rd         (rd),
        .out        (out_bus),
        .o_rd_valid (o_rd_valid),
        .o_valid    (o_valid),
        .o_full     (o_full),
        .o_overflow (o_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [BW-1:0]     q [COL][$];
    logic [COL*BW-1:0] exp_out;
    logic              exp_rv;
    logic              exp_ovf;
    int                pops;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic model_valid();
        for (int i = 0; i < COL; i++) if (q[i].size() == 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic model_full();
        for (int i = 0; i < COL; i++) if (q[i].size() == DEPTH) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < COL; i++) q[i].delete();
        exp_out = '0;
        exp_rv  = 1'b0;
        exp_ovf = 1'b0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".out"},      256'(out_bus),    256'(exp_out));
        check({tag, ".rd_valid"}, 256'(o_rd_valid), 256'(exp_rv));
        check({tag, ".overflow"}, 256'(o_overflow), 256'(exp_ovf));
        check({tag, ".valid"},    256'(o_valid),    256'(model_valid()));
        check({tag, ".full"},     256'(o_full),     256'(model_full()));
    endtask

    // One clock: drive, update the model from pre-edge occupancy, check after the edge.
    task automatic cycle(input string tag, input logic [COL-1:0] w,
                         input logic [COL*BW-1:0] d, input logic r);
        logic accept;
        logic full_pre [COL];
        wr = w; in_bus = d; rd = r;
        @(posedge clk);
        accept = r && model_valid();
        for (int i = 0; i < COL; i++) full_pre[i] = (q[i].size() == DEPTH);
        exp_rv = accept;
        if (accept) begin
            pops++;
            for (int i = 0; i < COL; i++) exp_out[i*BW +: BW] = q[i].pop_front();
        end
        for (int i = 0; i < COL; i++) begin
            if (w[i]) begin
                if (full_pre[i]) exp_ovf = 1'b1;
                else q[i].push_back(d[i*BW +: BW]);
            end
        end
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        wr = '0; rd = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check_all("reset");
    endtask

    function automatic logic [COL*BW-1:0] row_of(input int base, input logic neg);
        logic [COL*BW-1:0] r;
        logic [BW-1:0] v;
        r = '0;
        for (int i = 0; i < COL; i++) begin
            v = BW'(base + i);
            r[i*BW +: BW] = neg ? -v : v;
        end
        return r;
    endfunction

    function automatic logic [COL*BW-1:0] rand_row();
        logic [COL*BW-1:0] r;
        for (int i = 0; i < COL; i++) r[i*BW +: BW] = BW'($urandom);
        return r;
    endfunction

    initial begin
        int wprob;
        logic [COL-1:0] w;
        logic [COL*BW-1:0] expected_row;
        reset = 1'b1; wr = '0; in_bus = '0; rd = 1'b0;
        pops = 0;
        model_reset();
        do_reset();

        // 1: one full row then a pop
        cycle("t1.wr", 8'hFF, row_of(1, 1'b0), 1'b0);
        check("t1.valid_before_rd", 256'(o_valid), 256'(1));
        cycle("t1.rd", 8'h00, '0, 1'b1);
        expected_row = row_of(1, 1'b0);
        check("t1.row", 256'(out_bus), 256'(expected_row));
        cycle("t1.idle", 8'h00, '0, 1'b0);

        // 2: skewed column writes with rd held high
        pops = 0;
        for (int i = 0; i < COL; i++) cycle("t2.skew", COL'(1) << i, row_of(100, 1'b0), 1'b1);
        check("t2.no_early_pop", 256'(pops), 256'(0));
        cycle("t2.pop", 8'h00, '0, 1'b1);
        cycle("t2.tail", 8'h00, '0, 1'b1);
        check("t2.one_pop", 256'(pops), 256'(1));

        // 3: overfill column 0, then drain via the other columns
        for (int i = 0; i < DEPTH; i++) cycle("t3.fill", 8'h01, row_of(200 + i, 1'b0), 1'b0);
        check("t3.full", 256'(o_full), 256'(1));
        cycle("t3.extra", 8'h01, row_of(999, 1'b0), 1'b0);
        check("t3.overflow", 256'(o_overflow), 256'(1));
        for (int i = 0; i < DEPTH; i++) cycle("t3.others", 8'hFE, row_of(300 + i, 1'b0), 1'b0);
        for (int i = 0; i < DEPTH + 2; i++) cycle("t3.drain", 8'h00, '0, 1'b1);
        do_reset();

        // 4: 40 rows streaming through, alternating sign
        for (int v = 0; v < 40; v++) cycle("t4.stream", 8'hFF, row_of(v, v[0]), 1'b1);
        cycle("t4.last", 8'h00, '0, 1'b1);
        expected_row = row_of(39, 1'b1);
        check("t4.last_row", 256'(out_bus), 256'(expected_row));
        check("t4.no_overflow", 256'(o_overflow), 256'(0));

        // 5: rd on empty, then write+rd together, then rd
        cycle("t5.rd_empty", 8'h00, '0, 1'b1);
        cycle("t5.wr_rd", 8'hFF, row_of(50, 1'b1), 1'b1);
        check("t5.no_pulse", 256'(o_rd_valid), 256'(0));
        cycle("t5.pop", 8'h00, '0, 1'b1);
        expected_row = row_of(50, 1'b1);
        check("t5.row", 256'(out_bus), 256'(expected_row));

        // 6: async reset with 5 rows stored
        for (int i = 0; i < 5; i++) cycle("t6.fill", 8'hFF, row_of(60 + i, 1'b0), 1'b0);
        cycle("t6.pop", 8'h00, '0, 1'b1);
        wr = '0; rd = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all("t6.async");
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_all("t6.release");
        cycle("t6.rd_after", 8'h00, '0, 1'b1);

        // Random traffic with varying write density to reach full and empty
        for (int n = 0; n < 3000; n++) begin
            wprob = (n / 300) % 3 == 0 ? 90 : ((n / 300) % 3 == 1 ? 50 : 15);
            for (int i = 0; i < COL; i++) w[i] = ($urandom_range(99) < wprob);
            cycle("rand", w, rand_row(), $urandom_range(99) < 45);
            if (n == 1500) do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
